ota_trim_spi_slave: RTL

//  SPI mode-0 target that receives configuration frames from the chip pins and

---
 rtl/ota_trim_spi_slave.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/ota_trim_spi_slave.sv
// ============================================================================
// ota_trim_spi_slave
//
// SPI mode-0 target that holds the trim/control registers of the OTA analog
// core. Every SPI pin is oversampled on the system clock, so the design has a
// single clock domain. A frame is 16 bits, MSB first:
//   [15] rw (1 = write), [14:8] addr, [7:0] data
// Registers: REG0 bias_trim, REG1 offset_trim, REG2 gain_sel, REG3 control
// (only bit0 drives ota_en). Addresses >= 4 drop writes and read as 8'h00.
//
// Ports
//   clk          system clock, the only clock
//   rst_n        asynchronous active-low reset
//   ena          design selected; low abandons any frame, registers held
//   sclk         SPI clock (asynchronous, <= clk/4)
//   cs_n         SPI chip select, active low (asynchronous)
//   mosi         SPI data in, MSB first
//   miso         SPI data out, MSB first, 0 whenever miso_oe is 0
//   miso_oe      1 while a frame is selected
//   bias_trim    REG0
//   offset_trim  REG1
//   gain_sel     REG2
//   ota_en       REG3[0]
//   wr_stb       one-cycle pulse on every committed register write
//   err_cnt      saturating count of aborted (short) frames
// ============================================================================
module ota_trim_spi_slave #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] BIAS_RST    = 8'h80,
    parameter logic [7:0] OFFS_RST    = 8'h80,
    parameter logic [7:0] GAIN_RST    = 8'h01
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    output logic [7:0] bias_trim,
    output logic [7:0] offset_trim,
    output logic [7:0] gain_sel,
    output logic       ota_en,
    output logic       wr_stb,
    output logic [3:0] err_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Pin synchronizers and edge detection
    // ------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_prev;
    logic                   cs_prev;

    logic sclk_s;
    logic cs_s;
    logic mosi_s;
    logic sclk_rise;
    logic sclk_fall;
    logic cs_fall;

    // NOTE: sequential state is only ever assigned with <= so every flop
    // samples the pre-edge value of its neighbours, as a real register does.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            cs_sync   <= '1;   // deselected while in reset
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_prev <= sclk_s;
            cs_prev   <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign cs_fall   = cs_prev & ~cs_s;

    // ------------------------------------------------------------------------
    // Frame state
    // ------------------------------------------------------------------------
    state_t      state;
    logic [4:0]  bit_cnt;     // bits received so far, 0..16
    logic [14:0] rx_shift;    // first 15 bits; the 16th is taken from mosi_s
    logic [7:0]  tx_shift;
    logic        rd_frame;    // current frame is a read
    logic [7:0]  regs [4];

    // Header decode, valid on the cycle the 8th rising edge is seen.
    logic       hdr_done;
    logic       hdr_rw;
    logic [6:0] hdr_addr;
    // Full-frame decode, valid on the cycle the 16th rising edge is seen.
    logic       last_bit;
    logic       frm_rw;
    logic [6:0] frm_addr;
    logic [7:0] frm_data;
    logic [7:0] rd_data;

    assign hdr_done = sclk_rise && (bit_cnt == 5'd7);
    assign hdr_rw   = rx_shift[6];
    assign hdr_addr = {rx_shift[5:0], mosi_s};

    assign last_bit = sclk_rise && (bit_cnt == 5'd15);
    assign frm_rw   = rx_shift[14];
    assign frm_addr = rx_shift[13:7];
    assign frm_data = {rx_shift[6:0], mosi_s};

    // NOTE: the default assignment first keeps this mux purely combinational;
    // without it an unmatched address would infer a latch.
    always_comb begin
        rd_data = 8'h00;
        if (hdr_addr < 7'd4) begin
            rd_data = regs[hdr_addr[1:0]];
        end
    end

    // ------------------------------------------------------------------------
    // FSM, shifters, register file and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bit_cnt  <= 5'd0;
            rx_shift <= '0;
            tx_shift <= 8'h00;
            rd_frame <= 1'b0;
            miso     <= 1'b0;
            miso_oe  <= 1'b0;
            wr_stb   <= 1'b0;
            err_cnt  <= 4'h0;
            // NOTE: this small register file has architectural reset values
            // the analog core depends on, so unlike a RAM it is reset here.
            regs[0]  <= BIAS_RST;
            regs[1]  <= OFFS_RST;
            regs[2]  <= GAIN_RST;
            regs[3]  <= 8'h00;
        end else begin
            wr_stb <= 1'b0;

            if (!ena) begin
                // Deselected: drop the frame silently, registers are held.
                state   <= IDLE;
                bit_cnt <= 5'd0;
                miso_oe <= 1'b0;
                miso    <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (cs_fall) begin
                            state    <= HDR;
                            bit_cnt  <= 5'd0;
                            rd_frame <= 1'b0;
                            miso_oe  <= 1'b1;
                            miso     <= 1'b0;
                        end
                    end

                    HDR, DATA: begin
                        if (last_bit) begin
                            // Completion wins over a coincident cs_n rise.
                            state   <= DONE;
                            bit_cnt <= 5'd16;
                            if (frm_rw && (frm_addr < 7'd4)) begin
                                regs[frm_addr[1:0]] <= frm_data;
                                wr_stb              <= 1'b1;
                            end
                        end else if (cs_s) begin
                            state   <= IDLE;
                            bit_cnt <= 5'd0;
                            miso_oe <= 1'b0;
                            miso    <= 1'b0;
                            // A select pulse with no bits is not an abort.
                            if (((bit_cnt != 5'd0) || sclk_rise) && (err_cnt != 4'hF)) begin
                                err_cnt <= err_cnt + 4'd1;
                            end
                        end else begin
                            if (sclk_rise) begin
                                rx_shift <= {rx_shift[13:0], mosi_s};
                                bit_cnt  <= bit_cnt + 5'd1;
                                if (hdr_done) begin
                                    state    <= DATA;
                                    rd_frame <= ~hdr_rw;
                                    tx_shift <= rd_data;
                                end
                            end
                            // Falling edges 8..15 present read bits 7..0 so
                            // the initiator samples them on rising edges 9..16.
                            if (sclk_fall && (state == DATA) && rd_frame) begin
                                miso     <= tx_shift[7];
                                tx_shift <= {tx_shift[6:0], 1'b0};
                            end
                        end
                    end

                    DONE: begin
                        // Extra clocks past bit 16 are ignored.
                        if (cs_s) begin
                            state   <= IDLE;
                            bit_cnt <= 5'd0;
                            miso_oe <= 1'b0;
                            miso    <= 1'b0;
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bias_trim   = regs[0];
    assign offset_trim = regs[1];
    assign gain_sel    = regs[2];
    assign ota_en      = regs[3][0];

endmodule
